// File: rtl/instr_fetch_pkg.sv
// Shared RV32I core definitions: fetch FSM states, queue entry layout and the canonical NOP.
package instr_fetch_pkg;

    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;
    localparam logic [1:0]  QUEUE_DEPTH       = 2'd2;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_queue.sv
// Two-entry FIFO of fetched {pc, instr} pairs; flush wins over a simultaneous push.
module fetch_queue
    import instr_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_entry_i,
    input  logic         pop_i,
    output logic [1:0]   count_o,
    output fetch_entry_t head_o
);

    fetch_entry_t entry_q [2];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != QUEUE_DEPTH) || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
        if (do_push) wr_ptr_d = ~wr_ptr_q;
        if (do_pop)  rd_ptr_d = ~rd_ptr_q;
        if (flush_i) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload needs no reset: count_q alone decides whether an entry is live.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) entry_q[wr_ptr_q] <= push_entry_i;
    end

    assign count_o = count_q;
    assign head_o  = entry_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch.sv
// RV32I fetch stage: PC generation, single-outstanding imem requests, 2-deep instruction queue.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] idata,
    output logic [31:0] iaddr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        misaligned_fault
);

    fetch_state_t st_q, st_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic         fault_q;

    logic [1:0]   count;
    fetch_entry_t head;
    fetch_entry_t push_entry;
    logic         redirect_ok, response, push, pop, still_out, issue;
    logic [1:0]   count_after;
    logic [31:0]  req_addr;

    assign redirect_ok = redirect_valid && is_word_aligned(redirect_target);
    assign response    = (st_q != FETCH) && imem_rvalid;
    assign still_out   = (st_q != FETCH) && !imem_rvalid;
    assign push        = (st_q == WAIT) && imem_rvalid && !redirect_ok && !reset;
    assign pop         = instr_valid && instr_ready;

    // Occupancy as it will stand after this cycle's push/pop/flush, so a new
    // request is only launched when its word is guaranteed a free slot.
    always_comb begin
        count_after = count + {1'b0, push} - {1'b0, pop};
        if (redirect_ok) count_after = 2'd0;
    end

    assign issue = !reset && !still_out && (count_after < QUEUE_DEPTH);

    always_comb begin
        st_d       = st_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        req_addr   = redirect_ok ? redirect_target : fetch_pc_q;
        if (issue) begin
            st_d       = WAIT;
            req_pc_d   = req_addr;
            fetch_pc_d = req_addr + 32'd4;
        end else begin
            if (redirect_ok) fetch_pc_d = redirect_target;
            if (response) begin
                st_d = FETCH;
            end else if (st_q == WAIT && redirect_ok) begin
                st_d = DROP;
            end
        end
        if (reset) begin
            st_d       = FETCH;
            fetch_pc_d = RESET_PC;
            req_addr   = RESET_PC;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q       <= FETCH;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            fault_q    <= 1'b0;
        end else begin
            st_q       <= st_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            fault_q    <= redirect_valid && !is_word_aligned(redirect_target);
        end
    end

    assign push_entry = '{pc: req_pc_q, instr: imem_rdata};

    fetch_queue u_queue (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (redirect_ok),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .count_o      (count),
        .head_o       (head)
    );

    assign imem_req         = issue;
    assign imem_addr        = req_addr;
    assign instr_valid      = (count != 2'd0);
    assign idata            = instr_valid ? head.instr : NOP_INSTR;
    assign iaddr            = instr_valid ? head.pc : fetch_pc_q;
    assign misaligned_fault = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic against a queue-based reference model.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] KEY      = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] idata;
    logic [31:0] iaddr;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        misaligned_fault;

    int totalCount = 0;
    int badCount   = 0;
    int reqCount   = 0;
    int popCount   = 0;
    int memLat     = 1;
    bit checkEn    = 1'b0;

    bit          memBusy = 1'b0;
    logic [31:0] memAddr;
    int          memLeft;

    logic [31:0] mQ[$];
    logic [31:0] mPc      = RESET_PC;
    logic [31:0] mPendPc  = RESET_PC;
    bit          mPending = 1'b0;
    bit          mDrop    = 1'b0;
    bit          mFault   = 1'b0;

    instr_fetch #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk              (clk),
        .reset            (reset),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .idata            (idata),
        .iaddr            (iaddr),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .misaligned_fault (misaligned_fault)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalCount++;
        if (actual !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got %h, want %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic rdy, input logic rdir, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        reset           = rst;
        instr_ready     = rdy;
        redirect_valid  = rdir;
        redirect_target = tgt;
    endtask

    task automatic settle;
        @(negedge clk);
        #1;
    endtask

    task automatic doReset(input int lat, input logic rdy);
        repeat (3) applyStimulus(1'b1, rdy, 1'b0, 32'h0);
        memLat = lat;
    endtask

    // Memory: records each request mid-cycle and answers memLat cycles later with addr ^ KEY.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            memBusy = 1'b0;
        end else begin
            if (imem_req) begin
                memBusy = 1'b1;
                memAddr = imem_addr;
                memLeft = memLat;
                reqCount++;
            end
            if (instr_valid && instr_ready) popCount++;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (memBusy) begin
            memLeft--;
            if (memLeft == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memAddr ^ KEY;
                memBusy     = 1'b0;
            end
        end
    end

    // Reference model: a queue of delivered PCs plus "one request in flight / its word is stale" flags.
    task automatic modelStep;
        logic        expValid;
        logic [31:0] expData, expIaddr, expReqAddr;
        logic        expReq;
        bit          redirOk, popped;
        bit          keep     = 1'b0;
        bit          stillOut = 1'b0;
        int          occ;

        expValid   = mQ.size() != 0;
        expIaddr   = expValid ? mQ[0] : mPc;
        expData    = expValid ? (mQ[0] ^ KEY) : NOP;
        redirOk    = redirect_valid && (redirect_target[1:0] == 2'b00);
        popped     = expValid && instr_ready;
        expReq     = 1'b0;
        expReqAddr = RESET_PC;
        if (!reset) begin
            keep       = mPending && !mDrop && imem_rvalid && !redirOk;
            stillOut   = mPending && !imem_rvalid;
            occ        = redirOk ? 0 : (mQ.size() + int'(keep) - int'(popped));
            expReq     = !stillOut && (occ < 2);
            expReqAddr = redirOk ? redirect_target : mPc;
        end

        checkOutput("instr_valid", instr_valid, expValid);
        checkOutput("idata", idata, expData);
        checkOutput("iaddr", iaddr, expIaddr);
        checkOutput("misaligned_fault", misaligned_fault, mFault);
        checkOutput("imem_req", imem_req, expReq);
        if (expReq || reset) checkOutput("imem_addr", imem_addr, expReqAddr);

        if (reset) begin
            mQ.delete();
            mPc      = RESET_PC;
            mPending = 1'b0;
            mDrop    = 1'b0;
            mFault   = 1'b0;
        end else begin
            if (popped) void'(mQ.pop_front());
            if (keep) mQ.push_back(mPendPc);
            if (redirOk) mQ.delete();
            mFault = redirect_valid && (redirect_target[1:0] != 2'b00);
            if (expReq) begin
                mPending = 1'b1;
                mDrop    = 1'b0;
                mPendPc  = expReqAddr;
                mPc      = expReqAddr + 32'd4;
            end else begin
                if (redirOk) mPc = redirect_target;
                if (stillOut) mDrop = mDrop || redirOk;
                else mPending = 1'b0;
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (checkEn) modelStep();
    end

    initial begin
        int          found;
        logic [31:0] tgt;
        logic        rst;

        reset           = 1'b1;
        instr_ready     = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        imem_rvalid     = 1'b0;
        imem_rdata      = 32'h0;
        @(posedge clk);
        #1;
        checkEn = 1'b1;

        // Start-up streaming with a 1-cycle memory.
        doReset(1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        settle;
        checkOutput("start_req", imem_req, 1);
        checkOutput("start_addr0", imem_addr, 32'h0);
        checkOutput("start_empty", instr_valid, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        settle;
        checkOutput("start_addr4", imem_addr, 32'h4);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        settle;
        checkOutput("start_addr8", imem_addr, 32'h8);
        checkOutput("start_iaddr0", iaddr, 32'h0);
        checkOutput("start_idata0", idata, 32'hA5A5_A5A5);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        settle;
        checkOutput("start_iaddr4", iaddr, 32'h4);
        checkOutput("start_idata4", idata, 32'hA5A5_A5A1);

        // Backpressure: queue fills to two and requests stop.
        doReset(1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        reqCount = 0;
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        settle;
        checkOutput("bp_reqs", reqCount, 2);
        checkOutput("bp_valid", instr_valid, 1);
        checkOutput("bp_head", iaddr, 32'h0);
        checkOutput("bp_noreq", imem_req, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        settle;
        checkOutput("bp_rel_iaddr0", iaddr, 32'h0);
        checkOutput("bp_rel_addr8", imem_addr, 32'h8);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        settle;
        checkOutput("bp_rel_iaddr4", iaddr, 32'h4);
        checkOutput("bp_rel_addr12", imem_addr, 32'hC);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        settle;
        checkOutput("bp_rel_iaddr8", iaddr, 32'h8);

        // Redirect while the fetch of 8 is still in flight (3-cycle memory).
        doReset(3, 1'b1);
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
            settle;
            if (imem_req && imem_addr == 32'h8) found = 1;
        end
        checkOutput("redir_issue8", found, 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h100);
        settle;
        checkOutput("redir_hold", imem_req, 0);
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
            settle;
            if (instr_valid) begin
                found = 1;
                checkOutput("redir_first_iaddr", iaddr, 32'h100);
                checkOutput("redir_first_idata", idata, 32'hA5A5_A4A5);
            end
        end
        checkOutput("redir_delivered", found, 1);

        // Redirect in the same cycle as a response and a pop.
        doReset(1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        popCount = 0;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h200);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        settle;
        checkOutput("coinc_empty", instr_valid, 0);
        checkOutput("coinc_nop", idata, NOP);
        checkOutput("coinc_iaddr", iaddr, 32'h204);
        checkOutput("coinc_pops", popCount, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        settle;
        checkOutput("coinc_next", iaddr, 32'h200);

        // Misaligned redirect is ignored apart from the fault pulse.
        doReset(1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h102);
        settle;
        checkOutput("mis_addr8", imem_addr, 32'h8);
        checkOutput("mis_nofault_yet", misaligned_fault, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        settle;
        checkOutput("mis_fault", misaligned_fault, 1);
        checkOutput("mis_addr12", imem_addr, 32'hC);
        checkOutput("mis_iaddr4", iaddr, 32'h4);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        settle;
        checkOutput("mis_fault_clr", misaligned_fault, 0);
        checkOutput("mis_addr16", imem_addr, 32'h10);

        // PC wrap, fill the queue, then reset mid-run.
        doReset(1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        settle;
        checkOutput("wrap_top", imem_addr, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        settle;
        checkOutput("wrap_zero", imem_addr, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        settle;
        checkOutput("wrap_head", iaddr, 32'hFFFF_FFFC);
        checkOutput("wrap_full_noreq", imem_req, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        settle;
        checkOutput("wrap_full_valid", instr_valid, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        settle;
        checkOutput("rst_noreq", imem_req, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        settle;
        checkOutput("rst_empty", instr_valid, 0);
        checkOutput("rst_req", imem_req, 1);
        checkOutput("rst_addr", imem_addr, RESET_PC);
        checkOutput("rst_iaddr", iaddr, RESET_PC);

        // Random traffic: backpressure, redirects (some misaligned or near the wrap), resets.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            tgt = $urandom;
            if ($urandom_range(0, 7) == 0) tgt[31:4] = 28'hFFF_FFFF;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            applyStimulus(rst, ($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0), tgt);
            if (rst) memLat = $urandom_range(1, 3);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        settle;

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
